// File: rtl/vgpr_rd_port_arbiter.sv
// VGPR read-port arbiter: round-robin over SIMD/SIMF ports with a run-limited LSU
// priority lane, a registered RF read issue, and a tag pipe that realigns owners with data.

module vgpr_rd_tag_stage #(
  parameter int IDW = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           flush,
  input  logic           vld_in,
  input  logic [IDW-1:0] id_in,
  output logic           vld,
  output logic [IDW-1:0] id
);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld <= 1'b0;
      id  <= '0;
    end else begin
      vld <= vld_in & ~flush;
      id  <= id_in;
    end
  end
endmodule

module vgpr_rd_port_arbiter #(
  parameter  int NUM_PORTS  = 8,
  parameter  int ADDR_W     = 10,
  parameter  int DATA_W     = 2048,
  parameter  int RF_LAT     = 1,
  parameter  int MAX_HI_RUN = 4,
  localparam int IDW        = $clog2(NUM_PORTS + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_PORTS-1:0]        req,
  input  logic [NUM_PORTS*ADDR_W-1:0] req_addr,
  input  logic                        hi_req,
  input  logic [ADDR_W-1:0]           hi_addr,
  input  logic                        flush,
  output logic [NUM_PORTS-1:0]        gnt,
  output logic                        hi_gnt,
  output logic                        rf_rd_en,
  output logic [ADDR_W-1:0]           rf_rd_addr,
  input  logic [DATA_W-1:0]           rf_rd_data,
  output logic                        rsp_valid,
  output logic [IDW-1:0]              rsp_port,
  output logic [DATA_W-1:0]           rsp_data
);
  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic [NUM_PORTS-1:0][ADDR_W-1:0] port_addr;
  logic [PW-1:0]                    rr_ptr, rr_idx, scan;
  logic [NUM_PORTS-1:0]             rr_sel;
  logic [3:0]                       hi_run;
  logic                             any_req, hi_win, nrm_gnt, any_gnt;
  logic [ADDR_W-1:0]                gnt_addr;
  logic [IDW-1:0]                   gnt_id;
  int                               j;

  assign port_addr = req_addr;
  assign any_req   = |req;

  // First asserted request at or above rr_ptr, wrapping around.
  always_comb begin
    rr_sel = '0;
    rr_idx = '0;
    scan   = '0;
    j      = 0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      j = int'(rr_ptr) + i;
      if (j >= NUM_PORTS) j = j - NUM_PORTS;
      scan = PW'(j);
      if ((rr_sel == '0) && req[scan]) begin
        rr_sel[scan] = 1'b1;
        rr_idx       = scan;
      end
    end
  end

  // LSU wins unless it has used up its run while normal ports are waiting.
  assign hi_win  = hi_req & ~((hi_run == 4'(MAX_HI_RUN)) & any_req);
  assign hi_gnt  = rst & ~flush & hi_win;
  assign gnt     = (rst & ~flush & ~hi_win) ? rr_sel : '0;
  assign nrm_gnt = |gnt;
  assign any_gnt = hi_gnt | nrm_gnt;

  assign gnt_addr = hi_gnt ? hi_addr : port_addr[rr_idx];
  assign gnt_id   = hi_gnt ? IDW'(NUM_PORTS) : IDW'(rr_idx);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr     <= '0;
      hi_run     <= '0;
      rf_rd_en   <= 1'b0;
      rf_rd_addr <= '0;
    end else begin
      rf_rd_en <= any_gnt;
      if (any_gnt) rf_rd_addr <= gnt_addr;
      if (nrm_gnt) rr_ptr <= (rr_idx == PW'(NUM_PORTS - 1)) ? '0 : rr_idx + 1'b1;
      // Grants are blocked during flush, so bookkeeping freezes with them.
      if (!flush) begin
        if (nrm_gnt || !any_req) hi_run <= '0;
        else if (hi_gnt)         hi_run <= hi_run + 4'd1;
      end
    end
  end

  logic [RF_LAT:0]          vld_pipe, vld_in;
  logic [RF_LAT:0][IDW-1:0] id_pipe, id_in;

  assign vld_in = {vld_pipe[RF_LAT-1:0], any_gnt};
  assign id_in  = {id_pipe[RF_LAT-1:0], gnt_id};

  for (genvar k = 0; k <= RF_LAT; k++) begin : g_tag
    vgpr_rd_tag_stage #(.IDW(IDW)) u_stage (
      .clk    (clk),
      .rst    (rst),
      .flush  (flush),
      .vld_in (vld_in[k]),
      .id_in  (id_in[k]),
      .vld    (vld_pipe[k]),
      .id     (id_pipe[k])
    );
  end

  // A response landing in the flush cycle belongs to a pre-flush grant: drop it too.
  assign rsp_valid = vld_pipe[RF_LAT] & ~flush;
  assign rsp_port  = id_pipe[RF_LAT];
  assign rsp_data  = rf_rd_data;

endmodule

// File: tb/tb_vgpr_rd_port_arbiter.sv
// Directed bench for vgpr_rd_port_arbiter: a queue-based model checked every cycle,
// plus literal expectations for the reference scenarios.

module tb_vgpr_rd_port_arbiter;
  localparam int NP   = 8;
  localparam int AW   = 10;
  localparam int DW   = 64;
  localparam int LAT  = 1;
  localparam int MAXR = 4;

  logic              clk, rst;
  logic [NP-1:0]     req;
  logic [NP*AW-1:0]  req_addr;
  logic              hi_req, flush;
  logic [AW-1:0]     hi_addr;
  logic [NP-1:0]     gnt;
  logic              hi_gnt, rf_rd_en, rsp_valid;
  logic [AW-1:0]     rf_rd_addr;
  logic [DW-1:0]     rf_rd_data, rsp_data;
  logic [3:0]        rsp_port;

  int n_chk = 0, n_fail = 0;

  vgpr_rd_port_arbiter #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .RF_LAT(LAT),
                         .MAX_HI_RUN(MAXR)) dut (
    .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .hi_req(hi_req),
    .hi_addr(hi_addr), .flush(flush), .gnt(gnt), .hi_gnt(hi_gnt), .rf_rd_en(rf_rd_en),
    .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data), .rsp_valid(rsp_valid),
    .rsp_port(rsp_port), .rsp_data(rsp_data)
  );

  initial begin clk = 1'b0; forever #5 clk = ~clk; end

  initial begin
    rf_rd_data = '0;
    forever begin @(posedge clk); #1; rf_rd_data = {$urandom, $urandom}; end
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  typedef struct { int due; int id; } rsp_t;
  rsp_t          pend[$], keep[$], r;
  int            cyc = 0, m_rr = 0, m_hr = 0, e_id, e_rp, pp;
  logic          m_en = 1'b0, e_hi, e_rv;
  logic [AW-1:0] m_addr = '0, e_addr;
  logic [NP-1:0] e_gnt;

  always @(negedge clk) begin
    if (!rst) begin
      check("rst_gnt", gnt, 0);
      check("rst_hi_gnt", hi_gnt, 0);
      check("rst_rf_rd_en", rf_rd_en, 0);
      check("rst_rf_rd_addr", rf_rd_addr, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_port", rsp_port, 0);
      m_rr = 0; m_hr = 0; m_en = 1'b0; m_addr = '0;
      pend.delete();
    end else begin
      e_gnt = '0; e_hi = 1'b0; e_id = 0; e_addr = '0;
      if (!flush) begin
        if (hi_req && !(m_hr == MAXR && req != 0)) begin
          e_hi = 1'b1; e_id = NP; e_addr = hi_addr;
        end else begin
          for (int k = 0; k < NP; k++) begin
            pp = (m_rr + k) % NP;
            if (e_gnt == 0 && req[pp]) begin
              e_gnt[pp] = 1'b1; e_id = pp; e_addr = req_addr[pp*AW +: AW];
            end
          end
        end
      end
      e_rv = 1'b0; e_rp = 0;
      foreach (pend[q]) if (pend[q].due == cyc) begin e_rv = 1'b1; e_rp = pend[q].id; end
      if (flush) e_rv = 1'b0;

      check("gnt", gnt, e_gnt);
      check("hi_gnt", hi_gnt, e_hi);
      check("rf_rd_en", rf_rd_en, m_en);
      check("rf_rd_addr", rf_rd_addr, m_addr);
      check("rsp_valid", rsp_valid, e_rv);
      if (e_rv) check("rsp_port", rsp_port, e_rp);
      check("rsp_data", rsp_data, rf_rd_data);

      keep.delete();
      foreach (pend[q]) if (pend[q].due > cyc) keep.push_back(pend[q]);
      pend = keep;
      if (flush) pend.delete();
      m_en = e_hi || (e_gnt != 0);
      if (m_en) begin
        m_addr = e_addr;
        r.due = cyc + LAT + 1; r.id = e_id;
        pend.push_back(r);
      end
      if (!flush) begin
        if (e_gnt != 0)    begin m_rr = (e_id + 1) % NP; m_hr = 0; end
        else if (req == 0) m_hr = 0;
        else if (e_hi)     m_hr++;
      end
    end
    cyc++;
  end

  // ---------------- stimulus ----------------
  task automatic tick(); @(posedge clk); #1; endtask
  task automatic set_addr(input int p, input logic [AW-1:0] a); req_addr[p*AW +: AW] = a; endtask

  logic [NP-1:0] t_req [14] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00,
                                8'h0A, 8'h0A, 8'h0A, 8'h50, 8'h50, 8'h00, 8'h00};
  logic          t_hi  [14] = '{1, 1, 1, 1, 1, 1, 1, 0, 1, 1, 0, 0, 0, 0};
  logic          t_fl  [14] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0};

  initial begin
    rst = 1'b1; req = '0; req_addr = '0; hi_req = 1'b0; hi_addr = '0; flush = 1'b0;
    #2 rst = 1'b0;
    req = 8'hFF; hi_req = 1'b1;
    #2;
    check("reset_gnt_blocked", gnt, 0);
    check("reset_hi_blocked", hi_gnt, 0);
    check("reset_rf_rd_en", rf_rd_en, 0);
    check("reset_rsp_valid", rsp_valid, 0);
    repeat (2) tick();
    req = '0; hi_req = 1'b0; rst = 1'b1;

    // idle
    for (int k = 0; k < 10; k++) begin
      if (k > 0) tick();
      #3;
      check("idle_gnt", gnt, 0);
      check("idle_hi_gnt", hi_gnt, 0);
      check("idle_rf_rd_en", rf_rd_en, 0);
      check("idle_rsp_valid", rsp_valid, 0);
    end

    // round robin from rr_ptr=0
    for (int p = 0; p < NP; p++) set_addr(p, AW'(10'h100 + p));
    for (int k = 0; k < 11; k++) begin
      tick();
      req = (k < 9) ? 8'hFF : 8'h00;
      #3;
      if (k < 9) check("rr_gnt", gnt, 8'h01 << (k % NP));
      if (k >= 1 && k < 10) check("rr_rd_addr", rf_rd_addr, 10'h100 + ((k - 1) % NP));
      if (k >= 2) begin
        check("rr_rsp_valid", rsp_valid, 1);
        check("rr_rsp_port", rsp_port, (k - 2) % NP);
      end
    end

    // single read
    tick(); req = 8'h08; set_addr(3, 10'h05A); #3;
    check("single_gnt", gnt, 8'h08);
    tick(); req = '0; #3;
    check("single_rd_en", rf_rd_en, 1);
    check("single_rd_addr", rf_rd_addr, 10'h05A);
    tick(); #3;
    check("single_rsp_valid", rsp_valid, 1);
    check("single_rsp_port", rsp_port, 3);
    tick(); #3;
    check("single_rsp_done", rsp_valid, 0);

    // starvation guard
    set_addr(5, 10'h155);
    for (int k = 0; k < 6; k++) begin
      tick(); req = 8'h20; hi_req = 1'b1; hi_addr = AW'(10'h3C0 + k); #3;
      if (k == 4) begin
        check("starve_gnt5", gnt, 8'h20);
        check("starve_hi_off", hi_gnt, 0);
      end else begin
        check("starve_hi_gnt", hi_gnt, 1);
        check("starve_gnt_off", gnt, 0);
      end
      if (k == 2) check("starve_rsp_lsu", rsp_port, NP);
    end
    tick(); req = '0; hi_req = 1'b0;
    repeat (3) tick();

    // flush
    set_addr(0, 10'h011); set_addr(1, 10'h022);
    tick(); req = 8'h01; #3;
    check("flush_gnt0", gnt, 8'h01);
    tick(); req = 8'h02; flush = 1'b1; #3;
    check("flush_gnt_forced", gnt, 0);
    check("flush_rd_en_prev", rf_rd_en, 1);
    tick(); flush = 1'b0; #3;
    check("flush_rd_en_off", rf_rd_en, 0);
    check("flush_rsp_c2", rsp_valid, 0);
    check("flush_rr_kept", gnt, 8'h02);
    tick(); req = '0; #3;
    check("flush_rsp_c3", rsp_valid, 0);
    tick(); #3;
    check("flush_post_rsp_port", rsp_port, 1);
    repeat (2) tick();

    // reset mid-flight
    set_addr(2, 10'h0AA);
    tick(); req = 8'h04; #3;
    check("rstmid_gnt", gnt, 8'h04);
    tick(); req = '0; rst = 1'b0; #3;
    check("rstmid_rd_en", rf_rd_en, 0);
    check("rstmid_rsp", rsp_valid, 0);
    tick(); rst = 1'b1; req = 8'h81; set_addr(0, 10'h1E1); set_addr(7, 10'h1E7); #3;
    check("rstmid_first_gnt", gnt, 8'h01);
    check("rstmid_rsp_dropped", rsp_valid, 0);
    tick(); req = 8'h80; #3;
    check("rstmid_second_gnt", gnt, 8'h80);
    check("rstmid_rd_addr", rf_rd_addr, 10'h1E1);
    tick(); req = '0; #3;
    check("rstmid_rsp_port0", rsp_port, 0);
    tick(); #3;
    check("rstmid_rsp_port7", rsp_port, 7);

    // mixed vectors: model-only checking
    for (int k = 0; k < 14; k++) begin
      tick();
      req = t_req[k]; hi_req = t_hi[k]; flush = t_fl[k];
      req_addr = 80'({$urandom, $urandom, $urandom});
      hi_addr  = AW'($urandom);
    end
    tick(); req = '0; hi_req = 1'b0; flush = 1'b0;
    repeat (4) tick();

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
